bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
Shares one unified memory port between the core's instruction and data buses. It sits between rv32 and a single-ported RAM or peripheral interconnect. Data requests have fixed priority, because a stalled load/store blocks the pipeline. Instruction requests are protected from starvation, and a granted transaction is locked until the memory signals ready.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while an instruction request waits before instr is forced to win (range 1..255)
STARVE_WIDTH, 8, width of starvation counter

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
instr_address_in  in  32  instr bus address
instr_read_in  in  1  instr read request
instr_read_value_out  out  32  read data to instr master
instr_ready_out  out  1  instr transaction complete
data_address_in  in  32  data bus address
data_read_in  in  1  data read request
data_write_in  in  1  data write request
data_write_mask_in  in  4  byte enables
data_write_value_in  in  32  write data
data_read_value_out  out  32  read data to data master
data_ready_out  out  1  data transaction complete
mem_address_out  out  32  unified address
mem_read_out  out  1  unified read strobe
mem_write_out  out  1  unified write strobe
mem_write_mask_out  out  4  unified byte enables
mem_write_value_out  out  32  unified write data
mem_read_value_in  in  32  unified read data
mem_ready_in  in  1  unified completion
grant_out  out  2  debug: 00 none, 01 instr, 10 data

Behaviour:
- FSM states IDLE, INSTR, DATA; reset → IDLE, starve counter 0.
- All outputs are 0 while reset is low, including mem strobes and readys.
- IDLE arbitration, combinational with zero added latency:
  - data_req = data_read_in | data_write_in.
  - Winner = data if data_req and starve counter < STARVE_LIMIT; else instr if instr_read_in; else data if data_req; else none.
  - The winner's signals drive mem_* in the same cycle.
- If mem_ready_in is high in the arbitration cycle, the transaction completes the same cycle and the state stays IDLE. Otherwise the state moves to INSTR/DATA on the next edge.
- INSTR/DATA: mem_* is muxed from the locked master, and no re-arbitration takes place.
  - On mem_ready_in the state returns to IDLE on the next edge.
  - The next cycle re-arbitrates, so back-to-back transfers have no bubble.
- Instr source drives mem_write_out=0, mem_write_mask_out=0, mem_write_value_out=0.
- mem_read_value_in is broadcast to both *_read_value_out.
- mem_ready_in is routed only to the granted master's *_ready_out; the other ready stays 0.
- Starve counter:
  - increments, saturating at STARVE_LIMIT, on each completed data transfer while instr_read_in is high;
  - clears on each completed instr transfer or when instr_read_in is low.
- Protocol: masters hold request and payload stable until ready.
  - If the locked master drops its request before ready, the arbiter keeps the grant and forwards the dropped strobe. It does not abort.
  - A simulation assertion flags this case.
- data_read_in & data_write_in together is illegal; both are forwarded unchanged and an assertion fires.
- Reset mid-transaction: immediate IDLE, strobes low, counter 0. The memory must tolerate an abandoned transaction.

Optional Feature:
BUS_ARBITER_STARVE_GUARD_EN
- Defined: the starvation counter and STARVE_LIMIT override are present as described.
- Undefined: the counter is not instantiated and data has strict fixed priority. instr is granted only when data_req is low in IDLE. STARVE_LIMIT and STARVE_WIDTH are ignored.

Decomposition:
- Package bus_arbiter_pkg holds:
  - enum arb_state_t {ARB_IDLE, ARB_INSTR, ARB_DATA};
  - grant encoding constants GRANT_NONE/GRANT_INSTR/GRANT_DATA (2-bit).
- One sub-module, starve_counter: saturating counter with inc/clr/limit compare. It is instantiated only under BUS_ARBITER_STARVE_GUARD_EN.

Test Plan:
- Instr-only:
  - Stimulus: instr_read_in=1, addr 0x00000100, mem_ready_in high in the same cycle with value 0x00000013.
  - Required: mem_read_out=1 with mem_address_out=0x100 that cycle; instr_ready_out=1 with instr_read_value_out=0x13; grant_out=01; data_ready_out=0.
- Simultaneous:
  - Stimulus: instr read 0x200 and data write 0x8000_0004 (mask 0xF, value 0xDEADBEEF) both asserted in IDLE; mem_ready_in after 2 cycles.
  - Required: data is granted first, with mem_write_out=1 and mem_write_value_out=0xDEADBEEF held 3 cycles. Then data_ready_out pulses, and instr is granted on the next cycle with no bubble.
- Wait-state lock:
  - Stimulus: data read granted with mem_ready_in low 5 cycles; instr request arrives at cycle 2.
  - Required: grant stays 10 through all 5 cycles; instr_ready_out=0 throughout.
- Starvation (STARVE_GUARD_EN, STARVE_LIMIT=4):
  - Stimulus: continuous data reads and instr_read_in=1, single-cycle ready.
  - Required: 4 data grants, then 1 instr grant, then data again; counter returns to 0.
- Strict priority (macro undefined):
  - Stimulus: same as the starvation scenario.
  - Required: instr is never granted while data_req is high.
- Reset mid-transaction:
  - Stimulus: drive reset low during DATA state with mem_ready_in low.
  - Required: all strobes/readys go 0 immediately (asynchronously); after release the state is IDLE and grant_out=00.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared types for the instruction/data bus arbiter: FSM state encoding and
// the 2-bit grant code that is also exported on the debug grant port.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_INSTR = 2'd1,
    ARB_DATA  = 2'd2
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE  = 2'b00;
  localparam logic [1:0] GRANT_INSTR = 2'b01;
  localparam logic [1:0] GRANT_DATA  = 2'b10;

endpackage

// File: rtl/bus_arbiter_starve_counter.sv
// Saturating starvation counter for the bus arbiter. It counts data
// completions that happen while an instruction request waits, and reports
// whether data may still take priority. Only built when
// BUS_ARBITER_STARVE_GUARD_EN is defined.
`ifdef BUS_ARBITER_STARVE_GUARD_EN
module starve_counter #(
  parameter int LIMIT = 4,
  parameter int WIDTH = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic below_limit_o
);

  localparam logic [WIDTH-1:0] LimitVal = WIDTH'(LIMIT);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins over increment; increment stops once the limit is reached.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < LimitVal)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Counter register, cleared asynchronously by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign below_limit_o = (count_q < LimitVal);

endmodule
`endif

// File: rtl/bus_arbiter.sv
// Arbiter sharing one memory port between the instruction and data buses.
// Data has priority; a granted transfer is locked until mem_ready_in.
// Optional feature macro: BUS_ARBITER_STARVE_GUARD_EN (instruction
// starvation guard). Without it, data has strict fixed priority.
import bus_arbiter_pkg::*;

module bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address_in,
  input  logic        instr_read_in,
  output logic [31:0] instr_read_value_out,
  output logic        instr_ready_out,
  input  logic [31:0] data_address_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic [3:0]  data_write_mask_in,
  input  logic [31:0] data_write_value_in,
  output logic [31:0] data_read_value_out,
  output logic        data_ready_out,
  output logic [31:0] mem_address_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic [3:0]  mem_write_mask_out,
  output logic [31:0] mem_write_value_out,
  input  logic [31:0] mem_read_value_in,
  input  logic        mem_ready_in,
  output logic [1:0]  grant_out
);

  arb_state_t state_q;
  logic       dataReq;
  logic       dataFirst;
  logic [1:0] grantSel;

  assign dataReq = data_read_in | data_write_in;

`ifdef BUS_ARBITER_STARVE_GUARD_EN
  logic belowLimit;
  logic starveInc;
  logic starveClr;

  assign starveClr = ~instr_read_in | ((grantSel == GRANT_INSTR) & mem_ready_in);
  assign starveInc = (grantSel == GRANT_DATA) & mem_ready_in;
  assign dataFirst = dataReq & belowLimit;

  starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .WIDTH (STARVE_WIDTH)
  ) u_starve_counter (
    .clk_i         (clk),
    .rst_ni        (reset),
    .inc_i         (starveInc),
    .clr_i         (starveClr),
    .below_limit_o (belowLimit)
  );
`else
  // Strict priority ignores the starvation parameters; the tie-off keeps
  // them referenced.
  logic unusedParams;
  assign unusedParams = ^{STARVE_LIMIT, STARVE_WIDTH};
  assign dataFirst    = dataReq;
`endif

  // Pick the bus owner: the locked master while a transfer is open,
  // otherwise a fresh zero-latency arbitration.
  always_comb begin
    grantSel = GRANT_NONE;
    unique case (state_q)
      ARB_INSTR: grantSel = GRANT_INSTR;
      ARB_DATA:  grantSel = GRANT_DATA;
      default: begin
        if (dataFirst)          grantSel = GRANT_DATA;
        else if (instr_read_in) grantSel = GRANT_INSTR;
        else if (dataReq)       grantSel = GRANT_DATA;
      end
    endcase
  end

  // Steer the owner's request onto the memory port and route ready back;
  // everything is forced low while reset is held.
  always_comb begin
    mem_address_out     = '0;
    mem_read_out        = 1'b0;
    mem_write_out       = 1'b0;
    mem_write_mask_out  = '0;
    mem_write_value_out = '0;
    instr_ready_out     = 1'b0;
    data_ready_out      = 1'b0;
    grant_out           = GRANT_NONE;
    if (reset) begin
      grant_out = grantSel;
      if (grantSel == GRANT_INSTR) begin
        mem_address_out = instr_address_in;
        mem_read_out    = instr_read_in;
        instr_ready_out = mem_ready_in;
      end else if (grantSel == GRANT_DATA) begin
        mem_address_out     = data_address_in;
        mem_read_out        = data_read_in;
        mem_write_out       = data_write_in;
        mem_write_mask_out  = data_write_mask_in;
        mem_write_value_out = data_write_value_in;
        data_ready_out      = mem_ready_in;
      end
    end
  end

  assign instr_read_value_out = reset ? mem_read_value_in : '0;
  assign data_read_value_out  = reset ? mem_read_value_in : '0;

  // Lock FSM: enter a locked state only when the arbitration cycle did not
  // complete, and release on the cycle memory reports ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB_IDLE;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (!mem_ready_in) begin
            if (grantSel == GRANT_INSTR)     state_q <= ARB_INSTR;
            else if (grantSel == GRANT_DATA) state_q <= ARB_DATA;
          end
        end
        default: begin
          if (mem_ready_in) state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  // A locked master must keep its request up until memory completes it.
  assert property (@(posedge clk) disable iff (!reset)
                   (state_q == ARB_INSTR) |-> instr_read_in);
  assert property (@(posedge clk) disable iff (!reset)
                   (state_q == ARB_DATA) |-> dataReq);
  // Read and write together from the data master is illegal.
  assert property (@(posedge clk) disable iff (!reset)
                   !(data_read_in && data_write_in));

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: single-cycle vector table, hand-written
// multi-cycle sequences, and a randomized run against a transaction model.
module tb_bus_arbiter;

  localparam int Limit = 4;

  logic        clk;
  logic        reset;
  logic [31:0] instrAddr;
  logic        instrRead;
  logic [31:0] instrRVal;
  logic        instrReady;
  logic [31:0] dataAddr;
  logic        dataRead;
  logic        dataWrite;
  logic [3:0]  dataMask;
  logic [31:0] dataWVal;
  logic [31:0] dataRVal;
  logic        dataReady;
  logic [31:0] memAddr;
  logic        memRead;
  logic        memWrite;
  logic [3:0]  memMask;
  logic [31:0] memWVal;
  logic [31:0] memRVal;
  logic        memReady;
  logic [1:0]  grant;

  int checkCount = 0;
  int errorCount = 0;

  bus_arbiter #(.STARVE_LIMIT(Limit), .STARVE_WIDTH(8)) dut (
    .clk                  (clk),
    .reset                (reset),
    .instr_address_in     (instrAddr),
    .instr_read_in        (instrRead),
    .instr_read_value_out (instrRVal),
    .instr_ready_out      (instrReady),
    .data_address_in      (dataAddr),
    .data_read_in         (dataRead),
    .data_write_in        (dataWrite),
    .data_write_mask_in   (dataMask),
    .data_write_value_in  (dataWVal),
    .data_read_value_out  (dataRVal),
    .data_ready_out       (dataReady),
    .mem_address_out      (memAddr),
    .mem_read_out         (memRead),
    .mem_write_out        (memWrite),
    .mem_write_mask_out   (memMask),
    .mem_write_value_out  (memWVal),
    .mem_read_value_in    (memRVal),
    .mem_ready_in         (memReady),
    .grant_out            (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iRd;
    logic [31:0] iAddr;
    logic        dRd;
    logic        dWr;
    logic [31:0] dAddr;
    logic [3:0]  mask;
    logic [31:0] wVal;
    logic        rdy;
    logic [31:0] rVal;
    logic [1:0]  eGrant;
    logic        eMemRd;
    logic        eMemWr;
    logic [31:0] eAddr;
    logic [3:0]  eMask;
    logic [31:0] eWVal;
    logic        eIRdy;
    logic        eDRdy;
  } vec_t;

  vec_t vecs[7];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [1:0] eGrant,
                          input logic eMemRd, input logic eMemWr,
                          input logic [31:0] eAddr, input logic [3:0] eMask,
                          input logic [31:0] eWVal, input logic eIRdy,
                          input logic eDRdy, input logic [31:0] eRVal);
    checkOutput({tag, "/grant"}, 32'(grant), 32'(eGrant));
    checkOutput({tag, "/memRead"}, 32'(memRead), 32'(eMemRd));
    checkOutput({tag, "/memWrite"}, 32'(memWrite), 32'(eMemWr));
    checkOutput({tag, "/memAddr"}, memAddr, eAddr);
    checkOutput({tag, "/memMask"}, 32'(memMask), 32'(eMask));
    checkOutput({tag, "/memWVal"}, memWVal, eWVal);
    checkOutput({tag, "/instrReady"}, 32'(instrReady), 32'(eIRdy));
    checkOutput({tag, "/dataReady"}, 32'(dataReady), 32'(eDRdy));
    checkOutput({tag, "/instrRVal"}, instrRVal, eRVal);
    checkOutput({tag, "/dataRVal"}, dataRVal, eRVal);
  endtask

  task automatic applyStimulus(input logic iRd, input logic [31:0] iAddr,
                               input logic dRd, input logic dWr,
                               input logic [31:0] dAddr, input logic [3:0] mask,
                               input logic [31:0] wVal, input logic rdy,
                               input logic [31:0] rVal);
    instrRead = iRd;
    instrAddr = iAddr;
    dataRead  = dRd;
    dataWrite = dWr;
    dataAddr  = dAddr;
    dataMask  = mask;
    dataWVal  = wVal;
    memReady  = rdy;
    memRVal   = rVal;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    idleInputs();
    nextCycle();
    nextCycle();
    reset = 1'b1;
  endtask

  // Transaction-level reference for the randomized run.
  int owner;
  int starveCnt;
  logic       iPend, dPend, dIsWrite;
  logic [31:0] iAddrR, dAddrR, wValR;
  logic [3:0]  maskR;

  function automatic int predictGrant(input logic iRd, input logic dRd,
                                      input logic dWr);
    logic dReq;
    logic dataWins;
    dReq = dRd | dWr;
    if (owner != 0) return owner;
`ifdef BUS_ARBITER_STARVE_GUARD_EN
    dataWins = dReq && (starveCnt < Limit);
`else
    dataWins = dReq;
`endif
    if (dataWins) return 2;
    if (iRd)      return 1;
    if (dReq)     return 2;
    return 0;
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int g;
    int expGrant;
    reset = 1'b0;
    idleInputs();

    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h13,
                2'b01, 1'b1, 1'b0, 32'h100, 4'h0, 32'h0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b1, 32'hCAFE,
                2'b10, 1'b1, 1'b0, 32'h40, 4'h0, 32'h0, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h80000004, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,
                2'b10, 1'b0, 1'b1, 32'h80000004, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 32'h300, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 1'b1, 32'h77,
                2'b10, 1'b1, 1'b0, 32'h44, 4'h0, 32'h0, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h55,
                2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h400, 1'b0, 1'b1, 32'h48, 4'h3, 32'h12345678, 1'b1, 32'h0,
                2'b10, 1'b0, 1'b1, 32'h48, 4'h3, 32'h12345678, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h500, 1'b0, 1'b0, 32'hC0, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h9,
                2'b01, 1'b1, 1'b0, 32'h500, 4'h0, 32'h0, 1'b1, 1'b0};

    // Reset state: outputs low even with active requests.
    nextCycle();
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b1, 32'h99);
    @(negedge clk);
    checkAll("inReset", 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    idleInputs();
    reset = 1'b1;
    @(negedge clk);
    checkAll("afterReset", 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();

    // Single-cycle vector table, an idle cycle between rows.
    $display("[TB] vector table");
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].iRd, vecs[k].iAddr, vecs[k].dRd, vecs[k].dWr,
                    vecs[k].dAddr, vecs[k].mask, vecs[k].wVal, vecs[k].rdy,
                    vecs[k].rVal);
      @(negedge clk);
      checkAll($sformatf("vec%0d", k), vecs[k].eGrant, vecs[k].eMemRd,
               vecs[k].eMemWr, vecs[k].eAddr, vecs[k].eMask, vecs[k].eWVal,
               vecs[k].eIRdy, vecs[k].eDRdy, vecs[k].rVal);
      nextCycle();
      idleInputs();
      nextCycle();
    end

    // Simultaneous requests: data first, held 3 cycles, instr follows.
    $display("[TB] simultaneous");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 32'h200, 1'b0, 1'b1, 32'h80000004, 4'hF, 32'hDEADBEEF,
                    (c == 2), 32'h0);
      @(negedge clk);
      checkAll($sformatf("simul%0d", c), 2'b10, 1'b0, 1'b1, 32'h80000004, 4'hF,
               32'hDEADBEEF, 1'b0, (c == 2), 32'h0);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkAll("simulInstr", 2'b01, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    memReady = 1'b1;
    memRVal  = 32'h1234;
    @(negedge clk);
    checkAll("simulInstrDone", 2'b01, 1'b1, 1'b0, 32'h200, 4'h0, 32'h0, 1'b1, 1'b0, 32'h1234);
    nextCycle();
    idleInputs();
    nextCycle();

    // Wait-state lock: data read held 5 cycles, instr arrives in cycle 2.
    $display("[TB] wait-state lock");
    for (int c = 0; c < 6; c++) begin
      applyStimulus((c >= 1), 32'h700, 1'b1, 1'b0, 32'h60, 4'h0, 32'h0,
                    (c == 5), 32'hAB);
      @(negedge clk);
      checkAll($sformatf("lock%0d", c), 2'b10, 1'b1, 1'b0, 32'h60, 4'h0, 32'h0,
               1'b0, (c == 5), 32'hAB);
      nextCycle();
    end
    applyStimulus(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'hCD);
    @(negedge clk);
    checkAll("lockInstr", 2'b01, 1'b1, 1'b0, 32'h700, 4'h0, 32'h0, 1'b1, 1'b0, 32'hCD);
    nextCycle();
    idleInputs();
    nextCycle();

    // Starvation: continuous data reads with a waiting instr read.
    $display("[TB] starvation");
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b1, 32'h900, 1'b1, 1'b0, 32'hA0, 4'h0, 32'h0, 1'b1, 32'h5);
`ifdef BUS_ARBITER_STARVE_GUARD_EN
      expGrant = ((c % (Limit + 1)) == Limit) ? 1 : 2;
`else
      expGrant = 2;
`endif
      @(negedge clk);
      if (expGrant == 1)
        checkAll($sformatf("starve%0d", c), 2'b01, 1'b1, 1'b0, 32'h900, 4'h0, 32'h0,
                 1'b1, 1'b0, 32'h5);
      else
        checkAll($sformatf("starve%0d", c), 2'b10, 1'b1, 1'b0, 32'hA0, 4'h0, 32'h0,
                 1'b0, 1'b1, 32'h5);
      nextCycle();
    end
    idleInputs();
    nextCycle();

    // Reset in the middle of a locked data transfer.
    $display("[TB] reset mid-transaction");
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'hB0, 4'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    checkAll("rstPre", 2'b10, 1'b1, 1'b0, 32'hB0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    #1;
    reset = 1'b0;
    memReady = 1'b1;
    memRVal  = 32'h77;
    #1;
    checkAll("rstMid", 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    idleInputs();
    reset = 1'b1;
    @(negedge clk);
    checkAll("rstRelease", 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 32'h124, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1, 32'h3);
    @(negedge clk);
    checkAll("rstIdle", 2'b01, 1'b1, 1'b0, 32'h124, 4'h0, 32'h0, 1'b1, 1'b0, 32'h3);
    nextCycle();

    // Randomized traffic against the transaction model.
    $display("[TB] random traffic");
    doReset();
    owner = 0;
    starveCnt = 0;
    iPend = 1'b0;
    dPend = 1'b0;
    iAddrR = '0; dAddrR = '0; wValR = '0; maskR = '0; dIsWrite = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic rdy;
      logic [31:0] rVal;
      logic dRd, dWr;
      if (!iPend && ($urandom_range(0, 2) != 0)) begin
        iPend  = 1'b1;
        iAddrR = $urandom;
      end
      if (!dPend && ($urandom_range(0, 2) != 0)) begin
        dPend    = 1'b1;
        dIsWrite = $urandom_range(0, 1) == 1;
        dAddrR   = $urandom;
        maskR    = 4'($urandom);
        wValR    = $urandom;
      end
      rdy  = ($urandom_range(0, 2) != 0);
      rVal = $urandom;
      dRd  = dPend & ~dIsWrite;
      dWr  = dPend & dIsWrite;
      applyStimulus(iPend, iAddrR, dRd, dWr, dAddrR, maskR, wValR, rdy, rVal);
      g = predictGrant(iPend, dRd, dWr);
      @(negedge clk);
      if (g == 1)
        checkAll($sformatf("rnd%0d", c), 2'b01, 1'b1, 1'b0, iAddrR, 4'h0, 32'h0,
                 rdy, 1'b0, rVal);
      else if (g == 2)
        checkAll($sformatf("rnd%0d", c), 2'b10, dRd, dWr, dAddrR,
                 dWr ? maskR : (dRd ? maskR : 4'h0), wValR, 1'b0, rdy, rVal);
      else
        checkAll($sformatf("rnd%0d", c), 2'b00, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0,
                 1'b0, 1'b0, rVal);
      // Advance the model to the next cycle.
      if (!iPend || (g == 1 && rdy)) starveCnt = 0;
      else if (g == 2 && rdy && starveCnt < Limit) starveCnt++;
      if (g != 0) owner = rdy ? 0 : g;
      if (g == 1 && rdy) iPend = 1'b0;
      if (g == 2 && rdy) dPend = 1'b0;
      nextCycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
